// File: rtl/shadow_chain_capture.sv
// Shadow-chain dump collector: requests a dump from one of two scan chains,
// packs the returned serial stream LSB-first into WORD_W-bit words and
// queues them in a show-ahead FIFO for the debug reader.
module shadow_chain_capture #(
    parameter int WORD_W     = 32,
    parameter int FIFO_DEPTH = 8,
    parameter int TIMEOUT    = 1023
) (
    input  logic              sh_clk,
    input  logic              sh_rst_l,
    input  logic              dump_req,
    input  logic              dump_sel,
    output logic [1:0]        dump_en,
    input  logic [1:0]        ch_out,
    input  logic [1:0]        ch_out_vld,
    input  logic [1:0]        ch_out_done,
    input  logic              rd_en,
    output logic [WORD_W-1:0] rd_data,
    output logic              rd_empty,
    output logic              busy,
    output logic [15:0]       bit_count,
    output logic              overflow,
    output logic              timeout,
    input  logic              err_clr
);

    localparam int IDX_W  = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int IDLE_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_DUMP, S_FLUSH} state_t;

    state_t            state_q, state_d;
    logic              sel_q, sel_d;
    logic [WORD_W-1:0] shreg_q, shreg_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [IDLE_W-1:0] idle_q, idle_d;
    logic [15:0]       cnt_d;

    logic              vld_s, bit_s, done_s;
    logic              push, to_set, ovf_set, pop, wr_ok, full, empty;
    logic [WORD_W-1:0] push_word;

    logic [WORD_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W:0]    wr_ptr, rd_ptr;

    // Only the selected chain is observed; the other chain's lines are don't-care.
    assign vld_s  = ch_out_vld[sel_q];
    assign bit_s  = ch_out[sel_q];
    assign done_s = ch_out_done[sel_q];

    assign dump_en = (state_q == S_DUMP) ? (sel_q ? 2'b10 : 2'b01) : 2'b00;
    assign busy    = (state_q != S_IDLE);

    // Next-state, shift-register packing and word-push decisions.
    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        shreg_d   = shreg_q;
        idx_d     = idx_q;
        idle_d    = idle_q;
        cnt_d     = bit_count;
        push      = 1'b0;
        push_word = '0;
        to_set    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (dump_req) begin
                    state_d = S_DUMP;
                    sel_d   = dump_sel;
                    shreg_d = '0;
                    idx_d   = '0;
                    idle_d  = '0;
                    cnt_d   = '0;
                end
            end
            S_DUMP: begin
                if (vld_s) begin
                    // Starting a new word clears stale bits so a partial word
                    // flushed later is zero-padded above the last captured bit.
                    if (idx_q == '0) begin
                        shreg_d = '0;
                    end
                    shreg_d[idx_q] = bit_s;
                    idle_d         = '0;
                    if (bit_count != 16'hFFFF) begin
                        cnt_d = bit_count + 16'd1;
                    end
                    if (idx_q == IDX_W'(WORD_W - 1)) begin
                        push      = 1'b1;
                        push_word = shreg_d;
                        idx_d     = '0;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else if (idle_q != IDLE_W'(TIMEOUT - 1)) begin
                    idle_d = idle_q + IDLE_W'(1);
                end
                // An end-of-dump marker takes precedence over a coincident timeout.
                if (done_s) begin
                    state_d = S_FLUSH;
                end else if (!vld_s && (idle_q == IDLE_W'(TIMEOUT - 1))) begin
                    to_set  = 1'b1;
                    state_d = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (idx_q != '0) begin
                    push      = 1'b1;
                    push_word = shreg_q;
                end
                idx_d   = '0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Capture state, shift register and bit counter.
    always_ff @(posedge sh_clk or negedge sh_rst_l) begin
        if (!sh_rst_l) begin
            state_q   <= S_IDLE;
            sel_q     <= 1'b0;
            shreg_q   <= '0;
            idx_q     <= '0;
            idle_q    <= '0;
            bit_count <= '0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            shreg_q   <= shreg_d;
            idx_q     <= idx_d;
            idle_q    <= idle_d;
            bit_count <= cnt_d;
        end
    end

    // FIFO control: a pop frees the head slot in time for a same-edge push.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                     (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign pop     = rd_en && !empty;
    assign wr_ok   = push && (!full || pop);
    assign ovf_set = push && full && !pop;

    assign rd_empty = empty;
    assign rd_data  = empty ? '0 : mem[rd_ptr[PTR_W-1:0]];

    // FIFO read/write pointers.
    always_ff @(posedge sh_clk or negedge sh_rst_l) begin
        if (!sh_rst_l) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + (PTR_W + 1)'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + (PTR_W + 1)'(1);
            end
        end
    end

    // FIFO storage; contents are masked by rd_empty so no reset is needed.
    always_ff @(posedge sh_clk) begin
        if (wr_ok) begin
            mem[wr_ptr[PTR_W-1:0]] <= push_word;
        end
    end

    // Sticky error flags; a new error in the clearing cycle keeps the flag set.
    always_ff @(posedge sh_clk or negedge sh_rst_l) begin
        if (!sh_rst_l) begin
            overflow <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            if (ovf_set) begin
                overflow <= 1'b1;
            end else if (err_clr) begin
                overflow <= 1'b0;
            end
            if (to_set) begin
                timeout <= 1'b1;
            end else if (err_clr) begin
                timeout <= 1'b0;
            end
        end
    end

endmodule
